factor_scanner: RTL and testbench
=================================

# factor_scanner

- Sequential trial-division engine. Computes the divisibility bitmap of a 7-bit number by the divisors 2..9.
- Upstream of the digit-display sequencer: its `factors` output feeds that sequencer directly.
- Samples the switch value continuously and rescans automatically whenever it changes.
- Uses a bit-serial restoring remainder, one bit per cycle, so area stays small on the tile.

## Interface
- `clk`: input, 1 bit. Single clock, all state updates on rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `number`: input, 7 bits. Value to factor; unsigned, 0..127.
- `rescan`: input, 1 bit. Forces a new scan of the current `number` even if it is unchanged.
- `factors`: output, 8 bits. Bit k = 1 iff `number` mod (k+2) == 0, for k = 0..7. Registered.
- `valid`: output, 1 bit. `factors` corresponds to the latched number. Registered level.
- `done`: output, 1 bit. One-cycle pulse on each bitmap write.
- `busy`: output, 1 bit. High while in SCAN.
- No parameters.

## Operation
- Internal state:
  - `lat` (7 b): latched copy of `number`.
  - `pend` (1 b): scan request.
  - `state`: IDLE or SCAN.
  - `di` (3 b): divisor index; divisor d = di+2.
  - `bi` (3 b): bit index, 6..0.
  - `rem` (4 b): running remainder.
  - `acc` (8 b): bitmap under construction.
- Reset values: `factors`=0, `valid`=0, `done`=0, `busy`=0, state=IDLE, `pend`=1, `lat`=0, `acc`=0.
- Capture condition, evaluated at each edge while in IDLE or SCAN: `pend`=1, or `rescan`=1, or `number`≠`lat`.
- Capture edge actions:
  - `lat`←`number`, `pend`←0, `valid`←0.
  - `di`←0, `bi`←6, `rem`←0, `acc`←0.
  - state←SCAN.
- Capture has priority over any step, including the final step. Partial results are discarded, and `factors` keeps its previous value.
- SCAN step, one per edge when no capture occurs:
  - t = {`rem`,`lat[bi]`} (5 b, max 17).
  - `rem` ← (t ≥ d) ? t−d : t.
  - If `bi`=0: `acc[di]` ← (new `rem`==0), then `rem`←0 and `bi`←6. If `di`<7, `di`←`di`+1.
  - Otherwise `bi`←`bi`−1.
- Final step (`di`=7, `bi`=0):
  - `factors` ← `acc` with bit 7 from this step.
  - `valid`←1, `done`←1, state←IDLE.
- `done` is 0 on every other edge.
- Invariants:
  - `rem` < d after every step.
  - No divide hardware: subtraction and compare only.
  - All arithmetic is unsigned.
- `number`=0 yields `factors`=8'hFF (0 is divisible by everything). `number`=1 yields 8'h00.
- Reset asserted mid-scan returns to the reset state at that edge. The next edge with `reset` low captures, because `pend`=1.

## Timing
- Capture edge E. Steps occur at edges E+1..E+56 (8 divisors × 7 bits).
- `factors`, `valid` and `done` update at edge E+56, so latency is 56 cycles from capture.
- `busy` is high from E+1 through E+56 (visible after edge E, cleared at E+56).
- After reset deasserts: the first edge is capture, and results land 56 edges later.
- Input change with `number`≠`lat`:
  - In IDLE: capture at the next edge.
  - During SCAN: that edge recaptures, E restarts, and no `done` is issued for the aborted scan.
- `valid` drops at the capture edge. Between an input change and that edge (under one cycle), `valid` may be high for the old `lat`.
- `rescan` held high continuously recaptures every edge and never completes, by design.
- `rescan` coinciding with an input change is a single capture; no double scan.

## Test plan
- Reset with `number`=12, release → exactly 56 edges after first capture: `factors`=8'h17, `done` high one cycle, `valid`=1, `busy`=0.
- `number`=72 → 8'hD7. `number`=120 → 8'h5F. `number`=97 → 8'h00. `number`=127 → 8'h00. Each result after 56 cycles.
- `number`=0 → 8'hFF. `number`=1 → 8'h00.
- Abort case:
  - Stimulus: `number`=72; change to 120 at step 30.
  - Required: no `done` for 72; `factors` holds its prior value; `valid`=0; 8'h5F arrives 56 edges after the change-capture edge.
- Reset asserted at step 20 of a scan → all outputs 0 on the next edge. After release, a fresh scan of the current `number` completes 56 edges after capture.
- `rescan` pulsed in IDLE with an unchanged `number`:
  - Required: `valid` drops for 56 cycles, then the identical bitmap is rewritten with one `done` pulse.
  - Also: a `rescan` pulse on the same edge as a number change produces a single `done`.

Source files
------------

// File: rtl/factor_scanner_if.sv
// Bus between the switch/display side and the factor_scanner engine.
// The master drives the value to factor; the slave returns the bitmap and status.
interface factor_scanner_if;
    logic [6:0] number;
    logic       rescan;
    logic [7:0] factors;
    logic       valid;
    logic       done;
    logic       busy;

    modport master (output number, rescan, input factors, valid, done, busy);
    modport slave  (input number, rescan, output factors, valid, done, busy);
endinterface

// File: rtl/factor_scanner.sv
// Bit-serial trial division of a 7-bit value by 2..9, one remainder bit per cycle.
// Rescans automatically whenever the input changes or a rescan is requested.
module factor_scanner (
    input  logic             clk,
    input  logic             reset,
    factor_scanner_if.slave  bus
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t     state, state_nxt;
    logic [6:0] lat;
    logic       pend;
    logic [2:0] di, bi;
    logic [3:0] rem, rem_nxt;
    logic [7:0] acc;
    logic [4:0] t, d, t_sub;
    logic       capture, last;

    // A capture in any state restarts the scan and wins over the final step.
    always_comb begin
        capture   = pend | bus.rescan | (bus.number != lat);
        t         = {rem, lat[bi]};
        d         = {2'b00, di} + 5'd2;
        t_sub     = t - d;
        rem_nxt   = (t >= d) ? t_sub[3:0] : t[3:0];
        last      = (state == SCAN) && (di == 3'd7) && (bi == 3'd0) && !capture;
        state_nxt = state;
        if (capture)
            state_nxt = SCAN;
        else if (last)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    assign bus.busy = (state == SCAN);

    always_ff @(posedge clk) begin
        if (reset) begin
            lat         <= 7'd0;
            pend        <= 1'b1;
            di          <= 3'd0;
            bi          <= 3'd6;
            rem         <= 4'd0;
            acc         <= 8'd0;
            bus.factors <= 8'd0;
            bus.valid   <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (capture) begin
                lat       <= bus.number;
                pend      <= 1'b0;
                bus.valid <= 1'b0;
                di        <= 3'd0;
                bi        <= 3'd6;
                rem       <= 4'd0;
                acc       <= 8'd0;
            end else if (state == SCAN) begin
                if (bi == 3'd0) begin
                    acc[di] <= (rem_nxt == 4'd0);
                    rem     <= 4'd0;
                    bi      <= 3'd6;
                    if (di != 3'd7)
                        di <= di + 3'd1;
                    if (last) begin
                        bus.factors <= {rem_nxt == 4'd0, acc[6:0]};
                        bus.valid   <= 1'b1;
                        bus.done    <= 1'b1;
                    end
                end else begin
                    rem <= rem_nxt;
                    bi  <= bi - 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_factor_scanner.sv
// Directed vector bench for factor_scanner: table of values with hand-computed
// bitmaps, plus abort, reset-mid-scan and rescan sequences.
module tb_factor_scanner;
    logic clk = 1'b0;
    logic reset;
    factor_scanner_if bus ();

    factor_scanner dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] num;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];
    int   n_vec = 0;
    int   n_bad = 0;
    logic [7:0] prev_f;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Next edge is expected to capture; result must land exactly 56 edges later.
    task automatic run_scan(input logic [7:0] exp, input logic pulse, input string name);
        int dones;
        if (pulse) bus.rescan = 1'b1;
        step();
        bus.rescan = 1'b0;
        check({name, " cap_busy"},  {7'd0, bus.busy},  8'd1);
        check({name, " cap_valid"}, {7'd0, bus.valid}, 8'd0);
        check({name, " cap_hold"},  bus.factors, prev_f);
        dones = 0;
        for (int i = 0; i < 55; i++) begin
            step();
            dones += int'(bus.done);
        end
        check({name, " early_done"}, dones[7:0], 8'd0);
        step();
        check({name, " factors"}, bus.factors, exp);
        check({name, " done"},  {7'd0, bus.done},  8'd1);
        check({name, " valid"}, {7'd0, bus.valid}, 8'd1);
        check({name, " busy"},  {7'd0, bus.busy},  8'd0);
        step();
        check({name, " done_pulse"}, {7'd0, bus.done}, 8'd0);
        prev_f = exp;
    endtask

    initial begin
        int dones;
        vecs[0]  = '{7'd12,  8'h17};
        vecs[1]  = '{7'd72,  8'hD7};
        vecs[2]  = '{7'd120, 8'h5F};
        vecs[3]  = '{7'd97,  8'h00};
        vecs[4]  = '{7'd127, 8'h00};
        vecs[5]  = '{7'd0,   8'hFF};
        vecs[6]  = '{7'd1,   8'h00};
        vecs[7]  = '{7'd60,  8'h1F};
        vecs[8]  = '{7'd84,  8'h37};
        vecs[9]  = '{7'd45,  8'h8A};
        vecs[10] = '{7'd56,  8'h65};
        vecs[11] = '{7'd126, 8'hB3};

        reset      = 1'b1;
        bus.number = 7'd12;
        bus.rescan = 1'b0;
        prev_f     = 8'h00;
        step();
        step();
        check("rst_factors", bus.factors, 8'h00);
        check("rst_valid", {7'd0, bus.valid}, 8'd0);
        check("rst_done",  {7'd0, bus.done},  8'd0);
        check("rst_busy",  {7'd0, bus.busy},  8'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            bus.number = vecs[i].num;
            run_scan(vecs[i].exp, 1'b0, $sformatf("vec%0d_n%0d", i, vecs[i].num));
        end

        // Change input at step 30 of a scan of 72: recapture, no done for 72.
        bus.number = 7'd72;
        step();
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            dones += int'(bus.done);
        end
        bus.number = 7'd120;
        check("abort30_nodone", dones[7:0], 8'd0);
        run_scan(8'h5F, 1'b0, "abort30_120");

        // Change coinciding with the final step: capture wins, no done.
        bus.number = 7'd97;
        step();
        for (int i = 0; i < 55; i++) step();
        bus.number = 7'd1;
        step();
        check("abortlast_done",  {7'd0, bus.done}, 8'd0);
        check("abortlast_hold",  bus.factors, 8'h5F);
        check("abortlast_valid", {7'd0, bus.valid}, 8'd0);
        for (int i = 0; i < 55; i++) step();
        step();
        check("abortlast_res",  bus.factors, 8'h00);
        check("abortlast_done2", {7'd0, bus.done}, 8'd1);
        prev_f = 8'h00;

        // Reset at step 20 of a scan.
        bus.number = 7'd60;
        step();
        for (int i = 0; i < 20; i++) step();
        reset = 1'b1;
        step();
        check("midrst_factors", bus.factors, 8'h00);
        check("midrst_valid", {7'd0, bus.valid}, 8'd0);
        check("midrst_done",  {7'd0, bus.done},  8'd0);
        check("midrst_busy",  {7'd0, bus.busy},  8'd0);
        reset = 1'b0;
        prev_f = 8'h00;
        run_scan(8'h1F, 1'b0, "after_rst_60");

        // Rescan pulse in IDLE with unchanged number.
        run_scan(8'h1F, 1'b1, "rescan_same");

        // Rescan pulse coinciding with a number change: one scan, one done.
        bus.number = 7'd84;
        run_scan(8'h37, 1'b1, "rescan_change");
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            dones += int'(bus.done);
        end
        check("rescan_change_single", dones[7:0], 8'd0);
        check("idle_busy", {7'd0, bus.busy}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
